// File: rtl/frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : frame_scheduler
// Purpose  : Round-robin virtual-channel arbiter and frame sequencer for the
//            downlink framer; owns the 16-bit TxFN counter and keeps frames
//            back-to-back. Optional idle fill: FRAME_SCHED_IDLE_FILL_EN.
// Revision : 1.0 - initial release
// ============================================================================
module frame_scheduler #(
    parameter int NUM_CH   = 3,
    parameter int LEN_W    = 16,
    parameter int TIMEOUT  = 64,
    parameter int IDLE_LEN = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [NUM_CH-1:0]       req,
    input  logic [NUM_CH*LEN_W-1:0] req_len,
    output logic [NUM_CH-1:0]       grant,
    output logic                    start_frame,
    output logic [1:0]              frame_type,
    output logic [15:0]             txfn,
    output logic [LEN_W-1:0]        payload_len,
    input  logic                    fr_busy,
    input  logic                    fr_frame_done,
    output logic                    active,
    output logic                    err_timeout,
    input  logic                    err_clr,
    output logic [31:0]             frames_sent
);

    localparam int c_to_w = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t              r_state;
    logic [1:0]          r_ptr;
    logic [15:0]         r_txfn_cnt;
    logic [c_to_w-1:0]   r_to_cnt;
    logic                r_cur_idle;

    logic [NUM_CH-1:0]   w_elig;
    logic                w_any;
    logic [1:0]          w_sel;
    logic [NUM_CH-1:0]   w_sel_oh;
    logic [LEN_W-1:0]    w_sel_len;
    logic                w_arb_point;
    logic                w_done_ch;
    logic                w_go_ch;
    logic                w_go_idle;
    logic [15:0]         w_cnt_now;

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_elig
            assign w_elig[c] = req[c] & (|req_len[c*LEN_W +: LEN_W]);
        end
    endgenerate

    // Scan from the lowest rotation offset last so the channel right after
    // the previous grant wins.
    always_comb begin
        int j;
        w_any = 1'b0;
        w_sel = 2'd0;
        j     = 0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            j = int'(r_ptr) + i;
            if (j >= NUM_CH) begin
                j = j - NUM_CH;
            end
            if (w_elig[j]) begin
                w_any = 1'b1;
                w_sel = j[1:0];
            end
        end
    end

    always_comb begin
        w_sel_oh  = '0;
        w_sel_len = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_sel == 2'(c)) begin
                w_sel_oh[c] = 1'b1;
                w_sel_len   = req_len[c*LEN_W +: LEN_W];
            end
        end
    end

    assign w_arb_point = (r_state == S_IDLE) ||
                         ((r_state == S_WAIT_DONE) && fr_frame_done);
    assign w_done_ch   = (r_state == S_WAIT_DONE) && fr_frame_done && !r_cur_idle;
    assign w_cnt_now   = w_done_ch ? (r_txfn_cnt + 16'd1) : r_txfn_cnt;
    assign w_go_ch     = w_arb_point && enable && w_any;

`ifdef FRAME_SCHED_IDLE_FILL_EN
    assign w_go_idle   = w_arb_point && enable && !w_any;
`else
    assign w_go_idle   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ptr       <= 2'd0;
            r_txfn_cnt  <= 16'd0;
            r_to_cnt    <= '0;
            r_cur_idle  <= 1'b0;
            grant       <= '0;
            start_frame <= 1'b0;
            frame_type  <= 2'd0;
            txfn        <= 16'd0;
            payload_len <= '0;
            active      <= 1'b0;
            err_timeout <= 1'b0;
            frames_sent <= 32'd0;
        end else begin
            start_frame <= 1'b0;
            grant       <= '0;
            // A timeout raised below in the same cycle overrides this clear.
            if (err_clr) begin
                err_timeout <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    active <= 1'b0;
                end
                S_ISSUE: begin
                    r_to_cnt <= '0;
                    r_state  <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (fr_busy) begin
                        r_state <= S_WAIT_DONE;
                    end else if (r_to_cnt == c_to_w'(TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                        active      <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (fr_frame_done) begin
                        if (!r_cur_idle) begin
                            r_txfn_cnt  <= r_txfn_cnt + 16'd1;
                            frames_sent <= frames_sent + 32'd1;
                        end
                        active  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // Issue overrides the fall-back to IDLE so the next start_frame
            // lands in the cycle right after frame_done.
            if (w_go_ch || w_go_idle) begin
                r_state     <= S_ISSUE;
                start_frame <= 1'b1;
                active      <= 1'b1;
                txfn        <= w_cnt_now;
                if (w_go_ch) begin
                    grant       <= w_sel_oh;
                    frame_type  <= w_sel + 2'd1;
                    payload_len <= w_sel_len;
                    r_cur_idle  <= 1'b0;
                    r_ptr       <= (w_sel == 2'(NUM_CH - 1)) ? 2'd0 : (w_sel + 2'd1);
                end else begin
                    frame_type  <= 2'd0;
                    payload_len <= LEN_W'(IDLE_LEN);
                    r_cur_idle  <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_scheduler
// Purpose  : Directed, table-driven bench for frame_scheduler with a simple
//            framer model and a start_frame monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [2:0]  req = 3'b000;
    logic [47:0] req_len = 48'd0;
    logic [2:0]  grant;
    logic        start_frame;
    logic [1:0]  frame_type;
    logic [15:0] txfn;
    logic [15:0] payload_len;
    logic        fr_busy;
    logic        fr_frame_done;
    logic        active;
    logic        err_timeout;
    logic        err_clr = 1'b0;
    logic [31:0] frames_sent;

    frame_scheduler #(
        .NUM_CH   (3),
        .LEN_W    (16),
        .TIMEOUT  (64),
        .IDLE_LEN (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .req           (req),
        .req_len       (req_len),
        .grant         (grant),
        .start_frame   (start_frame),
        .frame_type    (frame_type),
        .txfn          (txfn),
        .payload_len   (payload_len),
        .fr_busy       (fr_busy),
        .fr_frame_done (fr_frame_done),
        .active        (active),
        .err_timeout   (err_timeout),
        .err_clr       (err_clr),
        .frames_sent   (frames_sent)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  req;
        logic [47:0] lens;
        logic [2:0]  grant;
        logic [1:0]  typ;
        logic [15:0] txfn;
        logic [15:0] len;
    } vec_t;

    typedef struct {
        logic [2:0]  grant;
        logic [1:0]  typ;
        logic [15:0] txfn;
        logic [15:0] len;
        int          gap;
    } rec_t;

    rec_t q[$];
    rec_t mon_r;
    int   n_start = 0;
    int   cyc = 0;
    int   last_done = -1000;
    int   n_chk = 0;
    int   n_pass = 0;
    int   fm_len = 6;
    bit   fm_silent = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic wait_starts(input int n, input int budget, input string nm);
        int k = 0;
        while (n_start < n && k < budget) begin
            @(posedge clk); #3;
            k++;
        end
        chk(nm, 32'(n_start >= n), 32'd1);
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int k = 0;
        while (active !== 1'b0 && k < budget) begin
            @(posedge clk); #3;
            k++;
        end
        chk(nm, 32'(active), 32'd0);
    endtask

    task automatic wait_err(input int budget, input string nm);
        int k = 0;
        while (err_timeout !== 1'b1 && k < budget) begin
            @(posedge clk); #3;
            k++;
        end
        chk(nm, 32'(err_timeout), 32'd1);
    endtask

    // Framer model: busy right after start_frame, done pulse after fm_len cycles.
    initial begin
        fr_busy       = 1'b0;
        fr_frame_done = 1'b0;
        forever begin
            if (start_frame === 1'b1 && !fm_silent) begin
                fr_busy = 1'b1;
                repeat (fm_len) @(posedge clk);
                #1;
                fr_busy       = 1'b0;
                fr_frame_done = 1'b1;
                @(posedge clk); #1;
                fr_frame_done = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end
    end

    // Monitor: logs every issued frame and its distance from the last done.
    initial begin
        forever begin
            @(posedge clk); #2;
            cyc++;
            if (fr_frame_done === 1'b1) last_done = cyc;
            if (start_frame === 1'b1) begin
                mon_r.grant = grant;
                mon_r.typ   = frame_type;
                mon_r.txfn  = txfn;
                mon_r.len   = payload_len;
                mon_r.gap   = cyc - last_done;
                q.push_back(mon_r);
                n_start++;
            end
        end
    end

    vec_t vt[6];
    vec_t bt[4];
    int   base;

    initial begin
        vt[0] = '{3'b001, {16'd0,     16'd0, 16'd20}, 3'b001, 2'd1, 16'h0000, 16'd20};
        vt[1] = '{3'b011, {16'd0,     16'd7, 16'd0 }, 3'b010, 2'd2, 16'h0001, 16'd7};
        vt[2] = '{3'b111, {16'd9,     16'd6, 16'd5 }, 3'b100, 2'd3, 16'h0002, 16'd9};
        vt[3] = '{3'b110, {16'd9,     16'd6, 16'd5 }, 3'b010, 2'd2, 16'h0003, 16'd6};
        vt[4] = '{3'b011, {16'd9,     16'd0, 16'd4 }, 3'b001, 2'd1, 16'h0004, 16'd4};
        vt[5] = '{3'b101, {16'hABCD,  16'd8, 16'd3 }, 3'b100, 2'd3, 16'h0005, 16'hABCD};
        bt[0] = '{3'b111, 48'd0, 3'b001, 2'd1, 16'h0000, 16'd10};
        bt[1] = '{3'b111, 48'd0, 3'b010, 2'd2, 16'h0001, 16'd11};
        bt[2] = '{3'b111, 48'd0, 3'b100, 2'd3, 16'h0002, 16'd12};
        bt[3] = '{3'b111, 48'd0, 3'b001, 2'd1, 16'h0003, 16'd10};

        // Reset state
        repeat (3) @(posedge clk);
        #3;
        chk("reset_ctrl", {27'd0, grant, start_frame, active, err_timeout}, 32'd0);
        chk("reset_frame", {frame_type, txfn, 14'd0}, 32'd0);
        chk("reset_len", 32'(payload_len), 32'd0);
        chk("reset_sent", frames_sent, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #3;

        // Single-frame vectors; enable drops mid-frame so each ends in IDLE
        fm_len = 6;
        for (int i = 0; i < 6; i++) begin
            req     = vt[i].req;
            req_len = vt[i].lens;
            enable  = 1'b1;
            wait_starts(i + 1, 20, $sformatf("v%0d_start", i));
            enable = 1'b0;
            chk($sformatf("v%0d_grant", i), 32'(q[i].grant), 32'(vt[i].grant));
            chk($sformatf("v%0d_type", i), 32'(q[i].typ), 32'(vt[i].typ));
            chk($sformatf("v%0d_txfn", i), 32'(q[i].txfn), 32'(vt[i].txfn));
            chk($sformatf("v%0d_len", i), 32'(q[i].len), 32'(vt[i].len));
            wait_idle(60, $sformatf("v%0d_idle", i));
            repeat (3) @(posedge clk);
            #3;
            chk($sformatf("v%0d_sent", i), frames_sent, 32'(i + 1));
            chk($sformatf("v%0d_nstart", i), 32'(n_start), 32'(i + 1));
        end

        // Zero-length request alone is never granted
        req     = 3'b001;
        req_len = 48'd0;
        enable  = 1'b1;
        repeat (12) @(posedge clk);
        #3;
        chk("zero_len_nstart", 32'(n_start), 32'd6);
        chk("zero_len_active", 32'(active), 32'd0);
        enable = 1'b0;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        chk("rst2_sent", frames_sent, 32'd0);

        // Back-to-back round robin with 30-cycle frames
        fm_len  = 30;
        req     = 3'b111;
        req_len = {16'd12, 16'd11, 16'd10};
        base    = n_start;
        enable  = 1'b1;
        wait_starts(base + 4, 200, "b2b_start");
        enable = 1'b0;
        wait_idle(60, "b2b_idle");
        repeat (5) @(posedge clk);
        #3;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("b2b%0d_grant", i), 32'(q[base+i].grant), 32'(bt[i].grant));
            chk($sformatf("b2b%0d_type", i), 32'(q[base+i].typ), 32'(bt[i].typ));
            chk($sformatf("b2b%0d_txfn", i), 32'(q[base+i].txfn), 32'(bt[i].txfn));
            chk($sformatf("b2b%0d_len", i), 32'(q[base+i].len), 32'(bt[i].len));
            if (i > 0) chk($sformatf("b2b%0d_gap", i), 32'(q[base+i].gap), 32'd1);
        end
        chk("b2b_nstart", 32'(n_start), 32'(base + 4));
        chk("b2b_sent", frames_sent, 32'd4);

        // TxFN wrap
        force dut.r_txfn_cnt = 16'hFFFE;
        @(posedge clk); #3;
        release dut.r_txfn_cnt;
        fm_len = 4;
        base   = n_start;
        enable = 1'b1;
        wait_starts(base + 3, 60, "wrap_start");
        enable = 1'b0;
        wait_idle(40, "wrap_idle");
        chk("wrap0_txfn", 32'(q[base].txfn), 32'h0000_FFFE);
        chk("wrap1_txfn", 32'(q[base+1].txfn), 32'h0000_FFFF);
        chk("wrap2_txfn", 32'(q[base+2].txfn), 32'h0000_0000);
        chk("wrap_sent", frames_sent, 32'd7);

        // Timeout: framer never goes busy
        fm_silent = 1'b1;
        req       = 3'b001;
        req_len   = {16'd0, 16'd0, 16'd5};
        base      = n_start;
        enable    = 1'b1;
        wait_starts(base + 1, 10, "to_start");
        chk("to_txfn0", 32'(q[base].txfn), 32'd1);
        repeat (30) @(posedge clk);
        #3;
        chk("to_early", 32'(err_timeout), 32'd0);
        wait_err(60, "to_err");
        wait_starts(base + 2, 10, "to_restart");
        chk("to_txfn_reuse", 32'(q[base+1].txfn), 32'd1);
        chk("to_sent", frames_sent, 32'd7);
        err_clr = 1'b1;
        @(posedge clk); #3;
        err_clr = 1'b0;
        chk("err_clr", 32'(err_timeout), 32'd0);
        err_clr = 1'b1;
        wait_err(100, "set_wins");
        err_clr = 1'b0;

        // Asynchronous reset mid-frame
        wait_starts(base + 3, 10, "rst_start");
        #4;
        rst_n = 1'b0;
        #1;
        chk("arst_ctrl", {27'd0, grant, start_frame, active, err_timeout}, 32'd0);
        chk("arst_frame", {frame_type, txfn, 14'd0}, 32'd0);
        chk("arst_sent", frames_sent, 32'd0);
        enable = 1'b0;
        @(posedge clk); #3;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
